req_gnt_arbiter: RTL and testbench

- Grant generator for the 3-channel req/gnt interface. It drives gnt[2:0] from req[2:0].
- Per-channel timing contract, as checked by the interface assertions:
  - ch0 is granted exactly 1 cycle after its request.
  - ch1 is granted within a 3–6 cycle window.
  - ch2 is granted in the same cycle as its request.
- ch0 and ch1 share a single-issue grant slot: ch1 slips around ch0 collisions. ch2 is an independent bypass.
- Sits directly upstream of the req/gnt protocol checkers. It is the DUT they observe.

---
 rtl/req_gnt_if.sv | 20 ++
 rtl/req_gnt_arbiter.sv | 121 ++++++++++++
 tb/tb_req_gnt_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/req_gnt_if.sv
// Request/grant bundle for the 3-channel arbiter. The master side drives
// requests; the slave side answers with grants and status flags.
interface req_gnt_if;
    logic [2:0] req;
    logic       gnt2_en;
    logic [2:0] gnt;
    logic       busy1;
    logic       slip_err;
    logic       drop_err;

    modport master (
        output req, gnt2_en,
        input  gnt, busy1, slip_err, drop_err
    );

    modport slave (
        input  req, gnt2_en,
        output gnt, busy1, slip_err, drop_err
    );
endinterface

// File: rtl/req_gnt_arbiter.sv
// Grant generator: ch0 registered one-cycle grant, ch1 latency-window grant that
// slips around ch0 collisions, ch2 combinational same-cycle bypass.
module req_gnt_arbiter #(
    parameter int GNT1_LAT = 3,
    parameter int GNT1_MAX = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    req_gnt_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

    localparam logic [2:0] LAT3 = 3'(GNT1_LAT);
    localparam logic [2:0] MAX3 = 3'(GNT1_MAX);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] slips_q, slips_d;
    logic       gnt0_q, gnt0_d;
    logic       req1_q, req1_d;
    logic       slip_err_q, slip_err_d;
    logic       drop_err_q, drop_err_d;

    logic [2:0] cnt_inc;
    logic [2:0] grant_point;

    assign cnt_inc     = cnt_q + 3'd1;
    assign grant_point = LAT3 + slips_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        slips_d    = slips_q;
        gnt0_d     = bus.req[0];
        req1_d     = bus.req[1];
        slip_err_d = slip_err_q;
        drop_err_d = drop_err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req[1]) begin
                    state_d = ST_WAIT;
                    cnt_d   = 3'd1;
                    slips_d = 3'd0;
                end
            end

            ST_WAIT: begin
                // Only a fresh rising level is a lost request; a held level is the accepted one.
                if (bus.req[1] && !req1_q) begin
                    drop_err_d = 1'b1;
                end
                if (cnt_inc == grant_point) begin
                    if (grant_point == MAX3) begin
                        state_d = ST_GRANT;
                        if (bus.req[0]) begin
                            slip_err_d = 1'b1;
                        end
                    end else if (bus.req[0]) begin
                        slips_d = slips_q + 3'd1;
                        cnt_d   = cnt_inc;
                    end else begin
                        state_d = ST_GRANT;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_GRANT: begin
                if (bus.req[1]) begin
                    state_d = ST_WAIT;
                    cnt_d   = 3'd1;
                    slips_d = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                    slips_d = 3'd0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
                slips_d = 3'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            slips_q    <= 3'd0;
            gnt0_q     <= 1'b0;
            req1_q     <= 1'b0;
            slip_err_q <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slips_q    <= slips_d;
            gnt0_q     <= gnt0_d;
            req1_q     <= req1_d;
            slip_err_q <= slip_err_d;
            drop_err_q <= drop_err_d;
        end
    end

    // ch2 is gated by rst_n so it cannot grant while the rest of the block is held in reset.
    assign bus.gnt      = {bus.req[2] & bus.gnt2_en & rst_n, state_q == ST_GRANT, gnt0_q};
    assign bus.busy1    = (state_q == ST_WAIT);
    assign bus.slip_err = slip_err_q;
    assign bus.drop_err = drop_err_q;

endmodule

// File: tb/tb_req_gnt_arbiter.sv
// Scoreboard bench for req_gnt_arbiter: stimulus queues per-edge expected output
// words {drop_err, slip_err, busy1, gnt[2:0]}; a monitor compares them mid-cycle.
module tb_req_gnt_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    req_gnt_if bus ();

    req_gnt_arbiter #(
        .GNT1_LAT (3),
        .GNT1_MAX (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         at;
        int         rel;
        logic [5:0] v;
        string      tag;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc      = 0;
    int         base     = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [5:0] tv [1:16];

    int         mon_now;
    logic [5:0] mon_act;
    exp_t       mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    // The value visible between edge k-1 and edge k is what edge k samples.
    always @(negedge clk) begin
        #1;
        mon_now = cyc + 1;
        mon_act = {bus.drop_err, bus.slip_err, bus.busy1, bus.gnt};
        while (sb_q.size() > 0 && sb_q[0].at <= mon_now) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            if (mon_e.at != mon_now) begin
                n_fail++;
                $display("FAIL %s edge %0d: not sampled in time (now %0d, due %0d)",
                         mon_e.tag, mon_e.rel, mon_now, mon_e.at);
            end else if (mon_act !== mon_e.v) begin
                n_fail++;
                $display("FAIL %s edge %0d: got {drop,slip,busy1,gnt}=%b expected %b",
                         mon_e.tag, mon_e.rel, mon_act, mon_e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [2:0] r, input logic en);
        bus.req     = r;
        bus.gnt2_en = en;
    endtask

    task automatic wait_edge(input int k);
        while (cyc < base + k - 1) @(negedge clk);
    endtask

    task automatic clear_tv;
        for (int k = 1; k <= 16; k++) tv[k] = 6'b0;
    endtask

    task automatic push_win(input int n, input string tag);
        for (int k = 1; k <= n; k++) begin
            sb_q.push_back('{at: base + k, rel: k, v: tv[k], tag: tag});
        end
    endtask

    task automatic drain;
        for (int i = 0; i < 64 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations never sampled", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Called at a negedge; all inputs driven high during reset to show outputs stay low.
    task automatic do_reset;
        rst_n = 1'b0;
        drive(3'b111, 1'b1);
        sb_q.push_back('{at: cyc + 1, rel: 0, v: 6'b0, tag: "reset"});
        sb_q.push_back('{at: cyc + 2, rel: 0, v: 6'b0, tag: "reset"});
        @(negedge clk);
        @(negedge clk);
        drive(3'b000, 1'b0);
        rst_n = 1'b1;
        base  = cyc;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(3'b000, 1'b0);
        @(negedge clk);

        // ch0 single pulse
        do_reset;
        clear_tv;
        tv[3] = 6'b000001;
        push_win(8, "ch0_pulse");
        wait_edge(2); drive(3'b001, 1'b0);
        wait_edge(3); drive(3'b000, 1'b0);
        drain;

        // ch1 nominal latency, req[1] held two edges (no drop)
        do_reset;
        clear_tv;
        tv[5] = 6'b001000; tv[6] = 6'b001000; tv[7] = 6'b000010;
        push_win(10, "ch1_nominal");
        wait_edge(4); drive(3'b010, 1'b0);
        wait_edge(6); drive(3'b000, 1'b0);
        drain;

        // ch1 single slip around ch0
        do_reset;
        clear_tv;
        tv[5] = 6'b001000; tv[6] = 6'b001000; tv[7] = 6'b001001; tv[8] = 6'b000010;
        push_win(10, "ch1_slip");
        wait_edge(4); drive(3'b010, 1'b0);
        wait_edge(5); drive(3'b000, 1'b0);
        wait_edge(6); drive(3'b001, 1'b0);
        wait_edge(7); drive(3'b000, 1'b0);
        drain;

        // ch1 forced at deadline together with ch0; slip_err sticky
        do_reset;
        clear_tv;
        tv[5]  = 6'b001000; tv[6]  = 6'b001000;
        tv[7]  = 6'b001001; tv[8]  = 6'b001001; tv[9] = 6'b001001;
        tv[10] = 6'b010011; tv[11] = 6'b010001;
        tv[12] = 6'b010000; tv[13] = 6'b010000; tv[14] = 6'b010000;
        push_win(14, "ch1_forced");
        wait_edge(4);  drive(3'b010, 1'b0);
        wait_edge(5);  drive(3'b000, 1'b0);
        wait_edge(6);  drive(3'b001, 1'b0);
        wait_edge(11); drive(3'b000, 1'b0);
        drain;

        // ch2 bypass gating, then all three channels at once
        do_reset;
        clear_tv;
        tv[2] = 6'b000100; tv[4] = 6'b000100; tv[5] = 6'b000001;
        tv[6] = 6'b000100; tv[7] = 6'b001001; tv[8] = 6'b001000; tv[9] = 6'b000010;
        push_win(11, "ch2_and_all");
        wait_edge(2); drive(3'b100, 1'b1);
        wait_edge(3); drive(3'b100, 1'b0);
        wait_edge(4); drive(3'b101, 1'b1);
        wait_edge(5); drive(3'b000, 1'b0);
        wait_edge(6); drive(3'b111, 1'b1);
        wait_edge(7); drive(3'b000, 1'b0);
        drain;

        // req[1] re-rises while busy1: drop_err sticky, single grant
        do_reset;
        clear_tv;
        tv[5] = 6'b001000; tv[6] = 6'b001000; tv[7] = 6'b100010;
        for (int k = 8; k <= 12; k++) tv[k] = 6'b100000;
        push_win(12, "ch1_drop");
        wait_edge(4); drive(3'b010, 1'b0);
        wait_edge(5); drive(3'b000, 1'b0);
        wait_edge(6); drive(3'b010, 1'b0);
        wait_edge(7); drive(3'b000, 1'b0);
        drain;

        // reset mid-wait aborts the pending ch1 grant
        do_reset;
        clear_tv;
        tv[5] = 6'b001000;
        push_win(14, "reset_abort");
        wait_edge(4); drive(3'b010, 1'b0);
        wait_edge(5); drive(3'b000, 1'b0);
        wait_edge(6); rst_n = 1'b0;
        wait_edge(8); rst_n = 1'b1;
        drain;

        do_reset;
        drain;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
